// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit packed-BCD stopwatch/timer controller with an internal tick prescaler.
// Lap snapshot, optional terminal-count limit with done pulse, and err on a bad limit.
module bcd_stopwatch_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [15:0] limit,
    output logic [15:0] q,
    output logic [15:0] lap_q,
    output logic        running,
    output logic        done,
    output logic        err
);

    // state | meaning
    // IDLE  | count held at 0000, waiting for a valid start
    // RUN   | prescaler advancing, count increments on each tick
    // PAUSE | prescaler and count frozen, start resumes
    // DONE  | count reached the latched limit, held until clear
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] lap_val_q, lap_val_d;
    logic [15:0] limit_q, limit_d;
    logic [15:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        tick;
    logic        limit_ok;
    logic [15:0] count_inc;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick      = (presc_q == DIV_M1);
    assign count_inc = bcd_inc(count_q);
    assign limit_ok  = (limit[3:0] <= 4'd9) && (limit[7:4] <= 4'd9) &&
                       (limit[11:8] <= 4'd9) && (limit[15:12] <= 4'd9);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lap_val_d = lap_val_q;
        limit_d   = limit_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Snapshot uses the pre-increment count, so a same-cycle tick is not seen.
        if (lap && (state_q == RUN || state_q == PAUSE)) begin
            lap_val_d = count_q;
        end

        case (state_q)
            IDLE: begin
                count_d = 16'h0000;
                presc_d = 16'd0;
                if (clear || stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    if (limit_ok) begin
                        limit_d = limit;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = 16'h0000;
                    presc_d = 16'd0;
                end else if (stop) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    presc_d = 16'd0;
                    count_d = count_inc;
                    if (limit_q != 16'h0000 && count_inc == limit_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = 16'h0000;
                    presc_d = 16'd0;
                end else if (!stop && start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = 16'h0000;
                    presc_d = 16'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 16'h0000;
            lap_val_q <= 16'h0000;
            limit_q   <= 16'h0000;
            presc_q   <= 16'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lap_val_q <= lap_val_d;
            limit_q   <= limit_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign q       = count_q;
    assign lap_q   = lap_val_q;
    assign running = running_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl: three instances (DIV=4, 1, 2) share the command inputs.
module tb_bcd_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] limit = 16'h0000;

    logic [15:0] q4, lap4, q1, lap1, q2, lap2;
    logic        run4, done4, err4, run1, done1, err1, run2, done2, err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .limit(limit), .q(q4), .lap_q(lap4), .running(run4), .done(done4), .err(err4)
    );
    bcd_stopwatch_ctrl #(.DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .limit(limit), .q(q1), .lap_q(lap1), .running(run1), .done(done1), .err(err1)
    );
    bcd_stopwatch_ctrl #(.DIV(2)) u_div2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .limit(limit), .q(q2), .lap_q(lap2), .running(run2), .done(done2), .err(err2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    initial begin
        int n_done;
        int done_at;
        logic [15:0] q_at_done;

        // Reset state and basic DIV=4 counting
        do_reset();
        check("rst_q", q4, 16'h0000);
        check("rst_lap", lap4, 16'h0000);
        check("rst_running", {15'd0, run4}, 16'd0);
        check("rst_done", {15'd0, done4}, 16'd0);
        check("rst_err", {15'd0, err4}, 16'd0);
        limit = 16'h0000;
        pulse_start();
        check("d4_running_after_start", {15'd0, run4}, 16'd1);
        check("d4_q_after_start", q4, 16'h0000);
        step(3);
        check("d4_q_before_tick", q4, 16'h0000);
        step(1);
        check("d4_first_tick", q4, 16'h0001);
        step(4);
        check("d4_second_tick", q4, 16'h0002);
        step(32);
        check("d4_q_40_cycles", q4, 16'h0010);

        // DIV=1 free run across all digit carries and the wrap
        do_reset();
        limit = 16'h0000;
        pulse_start();
        n_done = 0;
        for (int k = 1; k <= 10000; k++) begin
            step(1);
            if (done1) n_done++;
            if (k == 99 || k == 100 || k == 999 || k == 1000 || k == 9999 || k == 10000)
                check($sformatf("d1_q_at_%0d", k), q1, to_bcd(k % 10000));
        end
        check("d1_no_done", 16'(n_done), 16'd0);
        check("d1_still_running", {15'd0, run1}, 16'd1);

        // DIV=2 timer with limit 0025
        do_reset();
        limit = 16'h0025;
        pulse_start();
        n_done = 0;
        done_at = 0;
        q_at_done = 16'h0000;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (done2) begin
                n_done++;
                done_at = i;
                q_at_done = q2;
            end
        end
        check("d2_done_count", 16'(n_done), 16'd1);
        check("d2_done_cycle", 16'(done_at), 16'd50);
        check("d2_q_at_done", q_at_done, 16'h0025);
        check("d2_not_running", {15'd0, run2}, 16'd0);
        step(20);
        pulse_start();
        step(2);
        check("d2_q_held", q2, 16'h0025);
        check("d2_start_ignored", {15'd0, run2}, 16'd0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("d2_clear_q", q2, 16'h0000);
        pulse_start();
        check("d2_restart_from_idle", {15'd0, run2}, 16'd1);

        // DIV=4 pause/resume keeps the prescaler
        do_reset();
        limit = 16'h0000;
        pulse_start();
        step(5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("d4_q_at_stop", q4, 16'h0001);
        step(10);
        check("d4_q_paused", q4, 16'h0001);
        check("d4_paused_running", {15'd0, run4}, 16'd0);
        pulse_start();
        check("d4_resume_running", {15'd0, run4}, 16'd1);
        step(2);
        check("d4_resume_plus2", q4, 16'h0001);
        step(1);
        check("d4_resume_plus3", q4, 16'h0002);

        // stop coincident with a tick suppresses it; prescaler held at DIV-1
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("d4_stop_on_tick", q4, 16'h0002);
        pulse_start();
        check("d4_resume_at_held3", q4, 16'h0002);
        step(1);
        check("d4_tick_after_resume", q4, 16'h0003);

        // clear+start together in RUN returns to IDLE
        clear = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        check("d4_clear_start_running", {15'd0, run4}, 16'd0);
        check("d4_clear_start_q", q4, 16'h0000);
        step(8);
        check("d4_idle_hold_q", q4, 16'h0000);

        // lap coincident with a tick (DIV=1)
        do_reset();
        pulse_start();
        step(41);
        check("d1_q_0041", q1, 16'h0041);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("d1_lap_value", lap1, 16'h0041);
        check("d1_q_after_lap", q1, 16'h0042);

        // invalid limit rejected
        do_reset();
        limit = 16'h00A5;
        pulse_start();
        check("err_pulse", {15'd0, err4}, 16'd1);
        check("err_not_running", {15'd0, run4}, 16'd0);
        step(1);
        check("err_one_cycle", {15'd0, err4}, 16'd0);
        limit = 16'hA000;
        pulse_start();
        check("err_high_digit", {15'd0, err1}, 16'd1);

        // reset mid-RUN at q=0317 (DIV=1)
        do_reset();
        limit = 16'h0000;
        pulse_start();
        step(199);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("d1_lap_0199", lap1, 16'h0199);
        step(117);
        check("d1_q_0317", q1, 16'h0317);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_q", q1, 16'h0000);
        check("midrst_lap", lap1, 16'h0000);
        check("midrst_running", {15'd0, run1}, 16'd0);
        step(5);
        check("midrst_idle_q", q1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
